// File: rtl/flappy_game_ctrl.sv
// Per-frame game sequencer: bird physics, pipe-gap collision, death blink
// and game-over handling. All state advances only on frame_tick.
module flappy_game_ctrl #(
  parameter int Y_START       = 240,
  parameter int Y_MIN         = 6,
  parameter int Y_MAX         = 474,
  parameter int GAP_TOP       = 150,
  parameter int GAP_BOT       = 330,
  parameter int GRAVITY       = 1,
  parameter int FLAP_VEL      = 6,
  parameter int MAX_FALL      = 8,
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        flap,
  output logic [31:0] bird_y,
  output logic        inverted,
  output logic        game_over,
  output logic [15:0] score
);

  typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} state_t;

  localparam logic signed [7:0]  FlapVelNeg  = 8'(-FLAP_VEL);
  localparam logic signed [8:0]  MaxFallWide = 9'(MAX_FALL);
  localparam logic signed [10:0] YMinS       = 11'(Y_MIN);
  localparam logic signed [10:0] YMaxS       = 11'(Y_MAX);

  state_t             state_q, state_d;
  logic [9:0]         birdY_q, birdY_d;
  logic signed [7:0]  vel_q, vel_d;
  logic [15:0]        score_q, score_d;
  logic               inverted_q, inverted_d;
  logic [7:0]         blinkFrame_q, blinkFrame_d;
  logic [7:0]         blinkCount_q, blinkCount_d;
  logic               flapPrev_q;
  logic               flapPend_q, flapPend_d;

  logic               flapEdge, flapEff;
  logic signed [8:0]  velInc;
  logic signed [7:0]  velNext;
  logic signed [10:0] ySum;
  logic [9:0]         yClamped;
  logic [10:0]        yExt;
  logic               hit;
  logic [15:0]        scorePlus;

  // A flap edge arriving in the same cycle as the tick still counts for it.
  assign flapEdge = flap & ~flapPrev_q;
  assign flapEff  = flapPend_q | flapEdge;

  always_comb begin
    velInc   = {vel_q[7], vel_q} + 9'(GRAVITY);
    velNext  = flapEff ? FlapVelNeg
             : ((velInc > MaxFallWide) ? 8'(MAX_FALL) : velInc[7:0]);
    ySum     = $signed({1'b0, birdY_q}) + $signed({{3{velNext[7]}}, velNext});
    if (ySum < YMinS) begin
      yClamped = 10'(Y_MIN);
    end else if (ySum > YMaxS) begin
      yClamped = 10'(Y_MAX);
    end else begin
      yClamped = ySum[9:0];
    end
    yExt      = {1'b0, yClamped};
    hit       = ((yExt - 11'd6) <= 11'(GAP_TOP)) || ((yExt + 11'd5) >= 11'(GAP_BOT));
    scorePlus = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
  end

  always_comb begin
    state_d      = state_q;
    birdY_d      = birdY_q;
    vel_d        = vel_q;
    score_d      = score_q;
    inverted_d   = inverted_q;
    blinkFrame_d = blinkFrame_q;
    blinkCount_d = blinkCount_q;
    flapPend_d   = frame_tick ? 1'b0 : (flapPend_q | flapEdge);

    if (frame_tick) begin
      case (state_q)
        IDLE, PLAY: begin
          // IDLE only leaves on a flap, and then takes the same step as PLAY.
          if (state_q == PLAY || flapEff) begin
            birdY_d = yClamped;
            if (hit) begin
              vel_d        = '0;
              state_d      = DYING;
              blinkFrame_d = '0;
              blinkCount_d = '0;
            end else begin
              vel_d   = velNext;
              score_d = scorePlus;
              state_d = PLAY;
            end
          end
        end
        DYING: begin
          if (blinkFrame_q == 8'(BLINK_FRAMES - 1)) begin
            blinkFrame_d = '0;
            inverted_d   = ~inverted_q;
            if (blinkCount_q == 8'(BLINK_TOGGLES - 1)) begin
              blinkCount_d = '0;
              state_d      = OVER;
            end else begin
              blinkCount_d = blinkCount_q + 8'd1;
            end
          end else begin
            blinkFrame_d = blinkFrame_q + 8'd1;
          end
        end
        OVER: begin
          if (flapEff) begin
            state_d    = IDLE;
            birdY_d    = 10'(Y_START);
            vel_d      = '0;
            score_d    = '0;
            inverted_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    flapPrev_q <= flap;
    if (reset) begin
      state_q      <= IDLE;
      birdY_q      <= 10'(Y_START);
      vel_q        <= '0;
      score_q      <= '0;
      inverted_q   <= 1'b0;
      blinkFrame_q <= '0;
      blinkCount_q <= '0;
      flapPend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      birdY_q      <= birdY_d;
      vel_q        <= vel_d;
      score_q      <= score_d;
      inverted_q   <= inverted_d;
      blinkFrame_q <= blinkFrame_d;
      blinkCount_q <= blinkCount_d;
      flapPend_q   <= flapPend_d;
    end
  end

  assign bird_y    = {22'd0, birdY_q};
  assign inverted  = inverted_q;
  assign game_over = (state_q == OVER);
  assign score     = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: frame-level reference model compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_flappy_game_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        flap;
  logic [31:0] bird_y;
  logic        inverted;
  logic        game_over;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  string mMode;
  int    mY, mVel, mScore, mDying;
  bit    mPend, mPrev, modelValid;
  bit    mEdge, mEff;

  flappy_game_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .frame_tick(frame_tick),
    .flap      (flap),
    .bird_y    (bird_y),
    .inverted  (inverted),
    .game_over (game_over),
    .score     (score)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit t, input bit f);
    frame_tick = t;
    flap       = f;
    @(posedge clock);
    #1;
  endtask

  task automatic tickFrame(input bit f);
    applyStimulus(1'b1, f);
    applyStimulus(1'b0, f);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // One physics frame: hit band is y<=156 or y>=325 after the clamp.
  task automatic modelPlay(input bit eff);
    int v, y;
    v = eff ? -6 : ((mVel + 1 > 8) ? 8 : mVel + 1);
    y = mY + v;
    if (y < 6)   y = 6;
    if (y > 474) y = 474;
    mY = y;
    if (y <= 156 || y >= 325) begin
      mVel  = 0;
      mMode = "DYING";
      mDying = 0;
    end else begin
      mVel   = v;
      mScore = (mScore < 65535) ? mScore + 1 : 65535;
      mMode  = "PLAY";
    end
  endtask

  // Reference model: dying progress is a single frame count, 48 frames long.
  always @(posedge clock) begin
    if (reset) begin
      mMode = "IDLE"; mY = 240; mVel = 0; mScore = 0; mDying = 0; mPend = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      mEdge = flap && !mPrev;
      mEff  = mPend || mEdge;
      if (frame_tick) begin
        mPend = 0;
        if ((mMode == "IDLE" && mEff) || mMode == "PLAY") begin
          modelPlay(mEff);
        end else if (mMode == "DYING") begin
          mDying++;
          if (mDying == 48) begin
            mMode = "OVER";
            mDying = 0;
          end
        end else if (mMode == "OVER" && mEff) begin
          mMode = "IDLE"; mY = 240; mVel = 0; mScore = 0;
        end
      end else if (mEdge) begin
        mPend = 1;
      end
    end
    mPrev = flap;
  end

  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("model_bird_y", int'(bird_y), mY);
      checkOutput("model_score", int'(score), mScore);
      checkOutput("model_game_over", int'(game_over), (mMode == "OVER") ? 1 : 0);
      checkOutput("model_inverted", int'(inverted),
                  (mMode == "DYING" && ((mDying / 8) % 2) == 1) ? 1 : 0);
    end
  end

  int expY[4] = '{234, 229, 225, 222};

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    flap = 1'b0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    reset = 1'b0;

    // Idle ticks without flap
    repeat (10) tickFrame(1'b0);
    checkOutput("idle_bird_y", int'(bird_y), 240);
    checkOutput("idle_inverted", int'(inverted), 0);
    checkOutput("idle_game_over", int'(game_over), 0);
    checkOutput("idle_score", int'(score), 0);

    // Flap pulse between ticks, then ticks
    doReset();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("no_tick_bird_y", int'(bird_y), 240);
    for (int i = 0; i < 4; i++) begin
      tickFrame(1'b0);
      checkOutput("rise_bird_y", int'(bird_y), expY[i]);
      checkOutput("rise_score", int'(score), i + 1);
    end

    // One flap then free fall into the bottom flange, blink, game over
    doReset();
    tickFrame(1'b1);
    repeat (23) tickFrame(1'b0);
    checkOutput("fall_hit_bird_y", int'(bird_y), 327);
    checkOutput("fall_hit_score", int'(score), 23);
    repeat (7) tickFrame(1'b0);
    checkOutput("blink7_inverted", int'(inverted), 0);
    tickFrame(1'b0);
    checkOutput("blink8_inverted", int'(inverted), 1);
    repeat (39) tickFrame(1'b0);
    checkOutput("blink47_game_over", int'(game_over), 0);
    checkOutput("blink47_inverted", int'(inverted), 1);
    tickFrame(1'b0);
    checkOutput("over_game_over", int'(game_over), 1);
    checkOutput("over_inverted", int'(inverted), 0);
    checkOutput("over_score", int'(score), 23);
    checkOutput("over_bird_y", int'(bird_y), 327);
    tickFrame(1'b1);
    checkOutput("restart_game_over", int'(game_over), 0);
    checkOutput("restart_score", int'(score), 0);
    checkOutput("restart_bird_y", int'(bird_y), 240);
    tickFrame(1'b0);
    checkOutput("restart_idle_bird_y", int'(bird_y), 240);

    // Flap rising in the tick cycle, then held high
    doReset();
    applyStimulus(1'b1, 1'b1);
    checkOutput("same_cycle_bird_y", int'(bird_y), 234);
    applyStimulus(1'b0, 1'b1);
    repeat (20) tickFrame(1'b1);
    checkOutput("held_bird_y", int'(bird_y), 303);
    checkOutput("held_score", int'(score), 21);
    applyStimulus(1'b0, 1'b0);

    // Flap on every tick until the top flange
    doReset();
    repeat (14) begin
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("climb_bird_y", int'(bird_y), 156);
    checkOutput("climb_score", int'(score), 13);

    // Reset while dying with the palette inverted
    doReset();
    tickFrame(1'b1);
    repeat (23) tickFrame(1'b0);
    repeat (8) tickFrame(1'b0);
    checkOutput("predeath_inverted", int'(inverted), 1);
    doReset();
    checkOutput("mid_reset_bird_y", int'(bird_y), 240);
    checkOutput("mid_reset_inverted", int'(inverted), 0);
    checkOutput("mid_reset_score", int'(score), 0);
    checkOutput("mid_reset_game_over", int'(game_over), 0);
    tickFrame(1'b0);
    checkOutput("post_reset_idle_bird_y", int'(bird_y), 240);

    applyStimulus(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
